cc_driver: RTL
==============

Name: cc_driver

Overview:
- Synthesizable initiator for the CC coordinate-computation interface: in_valid/mode/xi/yi in, out_valid/xo/yo out.
- Takes one 4-point command from a host valid/ready port and serialises it onto the CC input bus.
- Streams CC's variable-length output back to the host and reports beat count, timeout and protocol errors.
- Sits between a command source (CPU/DMA/test sequencer) and the CC block, in place of the stimulus side of the CC bench.

Parameters:
- TIMEOUT, 1024: max cycles from last input beat to first cc_out_valid before abort.
- MAX_BEATS, 4096: beat_cnt saturation value.
- CNT_W, 13: width of beat_cnt; must satisfy 2^CNT_W > MAX_BEATS.
- GAP, 1: idle cycles forced between the end of one CC transaction and the next cc_in_valid.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-high (asserted = 1) despite the suffix.
- req_valid  in  1  host command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_mode  in  2  CC mode; 3 is reserved.
- req_pts  in  64  {x0,y0,x1,y1,x2,y2,x3,y3}, 8 bits each, x0 in bits 63:56.
- cc_in_valid  out  1  to CC in_valid.
- cc_mode  out  2  to CC mode.
- cc_xi, cc_yi  out  8 each  to CC xi/yi.
- cc_out_valid  in  1  from CC out_valid.
- cc_xo, cc_yo  in  8 each  from CC xo/yo.
- rsp_valid  out  1  one result beat; no backpressure.
- rsp_x, rsp_y  out  8 each  result beat data.
- done  out  1  one-cycle pulse at end of transaction.
- beat_cnt  out  CNT_W  beats received; valid while done=1, held until next accept.
- timeout  out  1  pulse coincident with done when TIMEOUT expired.
- proto_err  out  1  pulse when cc_out_valid arrives outside WAIT/RECV.

Behaviour:
- Reset: every output is 0 and the FSM is in IDLE. Reset mid-transaction aborts it with no done pulse. The command latch and counters clear.
- FSM states: IDLE, SEND, WAIT, RECV, FIN, GAPW.
- IDLE:
  - req_ready=1.
  - On accept with mode≠3: latch req_mode/req_pts and go to SEND.
  - On accept with mode=3: go to FIN with beat_cnt=0 and proto_err=1 in that FIN cycle. No CC traffic occurs.
- SEND: exactly 4 consecutive cycles with cc_in_valid=1.
  - Beat k drives cc_xi=xk, cc_yi=yk.
  - cc_mode = latched mode on beat 0 only, 0 on beats 1-3 and whenever cc_in_valid=0.
  - cc_xi/cc_yi are 0 when cc_in_valid=0.
  - All CC-side outputs are registered.
  - Goes to WAIT after beat 3.
- WAIT:
  - The timer counts from 1 on the first WAIT cycle.
  - cc_out_valid=1 goes to RECV, and that beat is counted.
  - Timer reaching TIMEOUT with no cc_out_valid goes to FIN with timeout=1.
- RECV: each cycle with cc_out_valid=1 increments beat_cnt, saturating at MAX_BEATS. The first cycle with cc_out_valid=0 goes to FIN.
- Response path: rsp_valid/rsp_x/rsp_y are cc_out_valid/cc_xo/cc_yo registered by one cycle, in WAIT/RECV only. Otherwise they are 0.
- FIN: single cycle; done=1 and beat_cnt is final. Then GAPW for GAP cycles (skipped if GAP=0), then IDLE.
- req_ready is 0 in all states except IDLE. There is no same-cycle accept at FIN.
- proto_err: cc_out_valid=1 in IDLE, SEND or GAPW gives a one-cycle pulse; the beat is not forwarded and state is unchanged.
- Timing relation: done occurs the cycle after the last rsp_valid beat. A zero-beat response is only possible via timeout or mode=3.

Decomposition:
- Shared package cc_pkg holds:
  - state enum cc_drv_state_t;
  - mode constants CC_MODE_TRAP=0, CC_MODE_CIRC=1, CC_MODE_AREA=2, CC_MODE_RSVD=3;
  - point struct {x,y} of 8 bits each;
  - CC_IN_BEATS=4.
- One sub-module, cc_drv_timer: loadable counter serving both the WAIT timeout and GAPW with a terminal-count output.

Test Plan:
- Mode 2, pts (0,0),(4,0),(4,3),(0,3); CC model returns 1 beat (0,12) three cycles after the last input beat:
  - cc_xi sequence 0,4,4,0 and cc_yi sequence 0,0,3,3;
  - cc_mode=2 on beat 0 only;
  - rsp (0,12) one cycle later, then done with beat_cnt=1.
- Mode 0, model returns 7 consecutive beats: 7 rsp beats matching in order; done with beat_cnt=7; req_ready low until GAP cycle elapsed.
- TIMEOUT=16 and the model never responds: timeout=done=1 on the 16th WAIT cycle, beat_cnt=0, rsp_valid never asserted.
- req_mode=3: no cc_in_valid; done=proto_err=1 one cycle after accept, beat_cnt=0.
- Spurious cc_out_valid during SEND beat 2: proto_err pulse; input beats still complete 4/4; transaction finishes normally.
- rst_n pulsed mid-RECV after 3 beats: all outputs 0 immediately (async), no done pulse; the next command runs cleanly and gives beat_cnt equal to the new count only.

Source files
------------

// File: rtl/cc_pkg.sv
// Shared definitions for the CC initiator: FSM state encoding, CC mode
// codes, the 8-bit point type and the point-select helper used to
// serialise a packed 4-point command onto the CC input bus.
package cc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_WAIT = 3'd2,
    ST_RECV = 3'd3,
    ST_FIN  = 3'd4,
    ST_GAPW = 3'd5
  } cc_drv_state_t;

  localparam logic [1:0] CC_MODE_TRAP = 2'd0;
  localparam logic [1:0] CC_MODE_CIRC = 2'd1;
  localparam logic [1:0] CC_MODE_AREA = 2'd2;
  localparam logic [1:0] CC_MODE_RSVD = 2'd3;

  localparam int CC_IN_BEATS = 4;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } cc_point_t;

  // Point k of a packed command {x0,y0,x1,y1,x2,y2,x3,y3}, x0 in the MSBs.
  function automatic cc_point_t cc_pt_sel(input logic [63:0] pts, input logic [1:0] k);
    cc_point_t p;
    case (k)
      2'd0:    p = pts[63:48];
      2'd1:    p = pts[47:32];
      2'd2:    p = pts[31:16];
      default: p = pts[15:0];
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cc_drv_timer.sv
// Loadable up-counter shared by the WAIT timeout and the GAPW idle gap.
// Ports:
//   clk, rst  : clock and asynchronous active-high reset
//   load      : restart the count at 1 (the first cycle of the timed state)
//   inc       : advance the count by one
//   limit     : terminal value for the state currently being timed
//   tc        : count equals limit
module cc_drv_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  input  logic [W-1:0] limit,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Count register: load wins over increment, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= {{(W-1){1'b0}}, 1'b1};
    end else if (inc) begin
      count_r <= count_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == limit);

endmodule

// File: rtl/cc_driver.sv
// CC initiator: accepts one 4-point command from a host valid/ready port,
// serialises it onto the CC input bus, forwards CC's variable-length result
// back to the host and reports beat count, timeout and protocol errors.
// Ports:
//   clk, rst_n         : clock; rst_n is an asynchronous ACTIVE-HIGH reset
//   req_*              : host command (mode, packed points) with valid/ready
//   cc_in_valid/mode/xi/yi : registered drive of the CC input bus
//   cc_out_valid/xo/yo : CC result stream
//   rsp_valid/x/y      : result beats, one cycle behind CC, no backpressure
//   done/beat_cnt/timeout/proto_err : end-of-transaction status
module cc_driver
  import cc_pkg::*;
#(
  parameter int TIMEOUT   = 1024,
  parameter int MAX_BEATS = 4096,
  parameter int CNT_W     = 13,
  parameter int GAP       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_mode,
  input  logic [63:0]      req_pts,
  output logic             cc_in_valid,
  output logic [1:0]       cc_mode,
  output logic [7:0]       cc_xi,
  output logic [7:0]       cc_yi,
  input  logic             cc_out_valid,
  input  logic [7:0]       cc_xo,
  input  logic [7:0]       cc_yo,
  output logic             rsp_valid,
  output logic [7:0]       rsp_x,
  output logic [7:0]       rsp_y,
  output logic             done,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             timeout,
  output logic             proto_err
);

  localparam int TMR_W = $clog2(TIMEOUT + GAP + 2);

  cc_drv_state_t state_r, state_s;
  logic [1:0]    idx_r;
  logic [63:0]   pts_r;
  logic          accept_s, rsvd_s, count_s, timeout_s, in_resp_s;
  logic          tmr_load_s, tmr_inc_s, tmr_tc_s;
  logic [TMR_W-1:0] tmr_limit_s;
  cc_point_t     pt_s;

  assign accept_s  = req_valid && req_ready && (state_r == ST_IDLE);
  assign rsvd_s    = (req_mode == CC_MODE_RSVD);
  assign in_resp_s = (state_r == ST_WAIT) || (state_r == ST_RECV);
  assign pt_s      = cc_pt_sel(pts_r, idx_r + 2'd1);

  cc_drv_timer #(.W(TMR_W)) u_timer (
    .clk   (clk),
    .rst   (rst_n),
    .load  (tmr_load_s),
    .inc   (tmr_inc_s),
    .limit (tmr_limit_s),
    .tc    (tmr_tc_s)
  );

  // Next-state logic, timer control and per-cycle beat/timeout events.
  always_comb begin
    state_s     = state_r;
    tmr_load_s  = 1'b0;
    tmr_inc_s   = 1'b0;
    tmr_limit_s = TMR_W'(TIMEOUT);
    count_s     = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = rsvd_s ? ST_FIN : ST_SEND;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (idx_r == 2'(CC_IN_BEATS - 1)) begin
          state_s    = ST_WAIT;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        // A beat on the terminal-count cycle still wins over the timeout.
        if (cc_out_valid) begin
          state_s = ST_RECV;
          count_s = 1'b1;
        end else if (tmr_tc_s) begin
          state_s   = ST_FIN;
          timeout_s = 1'b1;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      ST_RECV: begin
        if (cc_out_valid) begin
          count_s = 1'b1;
        end else begin
          state_s = ST_FIN;
        end
      end
      ST_FIN: begin
        if (GAP > 32'sd0) begin
          state_s    = ST_GAPW;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GAPW: begin
        tmr_limit_s = TMR_W'(GAP);
        if (tmr_tc_s) begin
          state_s = ST_IDLE;
        end else begin
          tmr_inc_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, beat index, command latch and host-side handshake/status.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r   <= ST_IDLE;
      idx_r     <= 2'd0;
      pts_r     <= 64'd0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state_r   <= state_s;
      req_ready <= (state_s == ST_IDLE);
      done      <= (state_s == ST_FIN);
      timeout   <= timeout_s;
      // Reserved mode is flagged in the FIN cycle; stray CC beats are
      // flagged one cycle after they arrive.
      proto_err <= (accept_s && rsvd_s) || (cc_out_valid && !in_resp_s);
      if (accept_s && !rsvd_s) begin
        pts_r <= req_pts;
      end else begin
        pts_r <= pts_r;
      end
      if (state_s == ST_SEND) begin
        idx_r <= (state_r == ST_SEND) ? idx_r + 2'd1 : 2'd0;
      end else begin
        idx_r <= 2'd0;
      end
    end
  end

  // CC input bus: beat 0 comes straight from the request at accept, beats
  // 1-3 from the latch; mode only on beat 0 and everything 0 when idle.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cc_in_valid <= 1'b0;
      cc_mode     <= 2'd0;
      cc_xi       <= 8'd0;
      cc_yi       <= 8'd0;
    end else if (accept_s && !rsvd_s) begin
      cc_in_valid <= 1'b1;
      cc_mode     <= req_mode;
      cc_xi       <= req_pts[63:56];
      cc_yi       <= req_pts[55:48];
    end else if ((state_r == ST_SEND) && (idx_r != 2'(CC_IN_BEATS - 1))) begin
      cc_in_valid <= 1'b1;
      cc_mode     <= 2'd0;
      cc_xi       <= pt_s.x;
      cc_yi       <= pt_s.y;
    end else begin
      cc_in_valid <= 1'b0;
      cc_mode     <= 2'd0;
      cc_xi       <= 8'd0;
      cc_yi       <= 8'd0;
    end
  end

  // Response forwarding, only while a response is legitimately expected.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rsp_valid <= 1'b0;
      rsp_x     <= 8'd0;
      rsp_y     <= 8'd0;
    end else if (in_resp_s && cc_out_valid) begin
      rsp_valid <= 1'b1;
      rsp_x     <= cc_xo;
      rsp_y     <= cc_yo;
    end else begin
      rsp_valid <= 1'b0;
      rsp_x     <= 8'd0;
      rsp_y     <= 8'd0;
    end
  end

  // Beat counter: cleared on accept, saturating, held after FIN.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      beat_cnt <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      beat_cnt <= {CNT_W{1'b0}};
    end else if (count_s && (beat_cnt != CNT_W'(MAX_BEATS))) begin
      beat_cnt <= beat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      beat_cnt <= beat_cnt;
    end
  end

endmodule
